// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage RV32I core.
// Loads and stores go out over an 8-bit memory port, one byte per transfer,
// little-endian. The pipeline stalls until the access finishes. ALU and link
// results pass straight through to writeback.
// Optional feature: define MEM_FWD_EN to drive the fwd_* bypass to ID. When it
// is not defined, fwd_* are tied to zero.

`ifndef LB
`define LB  6'h10
`endif
`ifndef LH
`define LH  6'h11
`endif
`ifndef LW
`define LW  6'h12
`endif
`ifndef LBU
`define LBU 6'h13
`endif
`ifndef LHU
`define LHU 6'h14
`endif
`ifndef SB
`define SB  6'h18
`endif
`ifndef SH
`define SH  6'h19
`endif
`ifndef SW
`define SW  6'h1A
`endif

module mem_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        status_in,
    input  logic [5:0]        op_in,
    input  logic [ADDR_W-1:0] mem_address_in,
    input  logic [ADDR_W-1:0] target_data_in,
    input  logic [4:0]        reg_address_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready,
    output logic              stall_req,
    output logic              wb_en,
    output logic [4:0]        wb_addr,
    output logic [ADDR_W-1:0] wb_data,
    output logic              fwd_valid,
    output logic [4:0]        fwd_addr,
    output logic [ADDR_W-1:0] fwd_data
);

    localparam logic [2:0] ST_NONE  = 3'b000;
    localparam logic [2:0] ST_REG   = 3'b001;
    localparam logic [2:0] ST_STORE = 3'b010;
    localparam logic [2:0] ST_LOAD  = 3'b011;
    localparam logic [2:0] ST_JAL   = 3'b101;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        last_q, last_d;     // index of the final byte (n-1)
    logic [ADDR_W-1:0] buf_q, buf_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] data_q, data_d;
    logic [5:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic              store_q, store_d;

    logic              is_mem;
    logic [ADDR_W-1:0] load_val;

    assign is_mem = (status_in == ST_STORE) || (status_in == ST_LOAD);

    // Index of the last byte of an access, from the opcode width
    function automatic logic [1:0] last_idx(input logic [5:0] op);
        case (op)
            `LB, `LBU, `SB: return 2'd0;
            `LH, `LHU, `SH: return 2'd1;
            default:        return 2'd3;
        endcase
    endfunction

    // Sign or zero extension of the assembled load buffer
    always_comb begin
        case (op_q)
            `LB:     load_val = {{(ADDR_W-8){buf_q[7]}}, buf_q[7:0]};
            `LBU:    load_val = {{(ADDR_W-8){1'b0}}, buf_q[7:0]};
            `LH:     load_val = {{(ADDR_W-16){buf_q[15]}}, buf_q[15:0]};
            `LHU:    load_val = {{(ADDR_W-16){1'b0}}, buf_q[15:0]};
            default: load_val = buf_q;
        endcase
    end

    // State, byte counter, buffer and latched request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= '0;
            buf_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            store_q <= store_d;
        end
    end

    // Next-state: latch a memory op in IDLE, walk its bytes in ACCESS
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        buf_d   = buf_q;
        addr_d  = addr_q;
        data_d  = data_q;
        op_d    = op_q;
        rd_d    = rd_q;
        store_d = store_q;
        case (state_q)
            IDLE: begin
                if (is_mem) begin
                    addr_d  = mem_address_in;
                    data_d  = target_data_in;
                    op_d    = op_in;
                    rd_d    = reg_address_in;
                    store_d = (status_in == ST_STORE);
                    last_d  = last_idx(op_in);
                    cnt_d   = '0;
                    buf_d   = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    if (!store_q)
                        buf_d[{cnt_q, 3'b000} +: 8] = mem_rdata;
                    if (cnt_q == last_q)
                        state_d = DONE;
                    else
                        cnt_d = cnt_q + 2'd1;
                end
            end
            DONE: begin
                // Upstream advances at the end of this cycle
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: all zero during reset, otherwise decoded from the state
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        stall_req = 1'b0;
        wb_en     = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (status_in == ST_REG || status_in == ST_JAL) begin
                        wb_en   = (reg_address_in != 5'd0);
                        wb_addr = reg_address_in;
                        wb_data = target_data_in;
                    end else if (is_mem) begin
                        stall_req = 1'b1;
                    end
                end
                ACCESS: begin
                    mem_req   = 1'b1;
                    mem_we    = store_q;
                    mem_addr  = addr_q + ADDR_W'(cnt_q);
                    mem_wdata = store_q ? data_q[{cnt_q, 3'b000} +: 8] : 8'h00;
                    stall_req = 1'b1;
                end
                DONE: begin
                    if (!store_q) begin
                        wb_en   = (rd_q != 5'd0);
                        wb_addr = rd_q;
                        wb_data = load_val;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_FWD_EN
    assign fwd_valid = wb_en;
    assign fwd_addr  = wb_addr;
    assign fwd_data  = wb_data;
`else
    assign fwd_valid = 1'b0;
    assign fwd_addr  = '0;
    assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized bench for mem_stage with a transaction-level
// reference model (byte memory plus spec-level load/store rules).

`ifndef LB
`define LB  6'h10
`endif
`ifndef LH
`define LH  6'h11
`endif
`ifndef LW
`define LW  6'h12
`endif
`ifndef LBU
`define LBU 6'h13
`endif
`ifndef LHU
`define LHU 6'h14
`endif
`ifndef SB
`define SB  6'h18
`endif
`ifndef SH
`define SH  6'h19
`endif
`ifndef SW
`define SW  6'h1A
`endif

module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  status_in;
    logic [5:0]  op_in;
    logic [31:0] mem_address_in, target_data_in;
    logic [4:0]  reg_address_in;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        stall_req, wb_en, fwd_valid;
    logic [4:0]  wb_addr, fwd_addr;
    logic [31:0] wb_data, fwd_data;

    always #5 clk = ~clk;

    mem_stage #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .status_in(status_in), .op_in(op_in),
        .mem_address_in(mem_address_in), .target_data_in(target_data_in),
        .reg_address_in(reg_address_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall_req(stall_req), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
        .fwd_data(fwd_data)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, obs, exp);
    endtask

    // Environment memory answers the DUT; reference memory follows the spec
    logic [7:0] env_mem [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    function automatic logic [7:0] env_rd(input logic [31:0] a);
        if (env_mem.exists(a)) return env_mem[a];
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic int op_len(input logic [5:0] op);
        if (op == `LB || op == `LBU || op == `SB) return 1;
        if (op == `LH || op == `LHU || op == `SH) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] a);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < op_len(op); i++)
            v = v | (32'(ref_rd(a + 32'(i))) << (8 * i));
        if (op == `LB && v[7])  v = v | 32'hFFFFFF00;
        if (op == `LH && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    // Present one instruction, act as memory, and check the whole transaction
    task automatic run_op(input logic [2:0] st, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] d, input logic [4:0] rd, input int dly);
        int          stalls = 0, wctr = 0, n;
        bit          unstable = 0, done = 0, is_mem, is_st, exp_en;
        logic [31:0] xa[$];
        logic [7:0]  xd[$];
        logic        xw[$];
        logic [31:0] cur_a = 0, exp_data = 0, o_data = 0, o_fd = 0;
        logic [7:0]  cur_d = 0;
        logic        cur_w = 0, o_en = 0, o_fv = 0;
        logic [4:0]  o_addr = 0, o_fa = 0;
        is_mem = (st == 3'b010) || (st == 3'b011);
        is_st  = (st == 3'b010);
        n      = op_len(op);
        status_in = st; op_in = op; mem_address_in = a;
        target_data_in = d; reg_address_in = rd;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (stall_req) stalls++;
            if (mem_req) begin
                if (wctr == 0) begin
                    cur_a = mem_addr; cur_w = mem_we; cur_d = mem_wdata;
                end else if (mem_addr !== cur_a || mem_we !== cur_w || mem_wdata !== cur_d) begin
                    unstable = 1;
                end
                if (wctr == dly) begin
                    mem_ready = 1'b1;
                    mem_rdata = env_rd(mem_addr);
                    if (mem_we) env_mem[mem_addr] = mem_wdata;
                    xa.push_back(mem_addr); xw.push_back(mem_we); xd.push_back(mem_wdata);
                    wctr = 0;
                end else begin
                    wctr++;
                end
            end
            if (!stall_req) begin
                done = 1;
                o_en = wb_en; o_addr = wb_addr; o_data = wb_data;
                o_fv = fwd_valid; o_fa = fwd_addr; o_fd = fwd_data;
            end
            @(posedge clk); #1;
            mem_ready = 1'b0;
        end
        status_in = 3'b000;
        if (!done) chk("timeout", 32'd0, 32'd1);

        exp_en = 0;
        if (st == 3'b001 || st == 3'b101) begin
            exp_en = (rd != 0); exp_data = d;
        end else if (st == 3'b011) begin
            exp_en = (rd != 0); exp_data = ref_load(op, a);
        end
        chk("wb_en", 32'(o_en), 32'(exp_en));
        if (exp_en) begin
            chk("wb_addr", 32'(o_addr), 32'(rd));
            chk("wb_data", o_data, exp_data);
        end
`ifdef MEM_FWD_EN
        chk("fwd_valid", 32'(o_fv), 32'(exp_en));
        if (exp_en) begin
            chk("fwd_addr", 32'(o_fa), 32'(rd));
            chk("fwd_data", o_fd, exp_data);
        end
`else
        chk("fwd_valid", 32'(o_fv), 32'd0);
        chk("fwd_addr", 32'(o_fa), 32'd0);
        chk("fwd_data", o_fd, 32'd0);
`endif
        chk("stall_cycles", 32'(stalls), is_mem ? 32'(1 + n * (dly + 1)) : 32'd0);
        if (is_mem) begin
            chk("xfer_count", 32'(xa.size()), 32'(n));
            for (int i = 0; i < n && i < xa.size(); i++) begin
                chk("xfer_addr", xa[i], a + 32'(i));
                chk("xfer_we", 32'(xw[i]), 32'(is_st));
                if (is_st) chk("xfer_wdata", 32'(xd[i]), 32'(d[8*i +: 8]));
            end
            chk("mem_stable", 32'(unstable), 32'd0);
        end
        if (is_st)
            for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = d[8*i +: 8];
    endtask

    logic [5:0] ld_ops [5] = '{`LB, `LH, `LW, `LBU, `LHU};
    logic [5:0] st_ops [3] = '{`SB, `SH, `SW};
    logic [2:0] sts    [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011};

    initial begin
        bit hit;
        rst = 1'b1; status_in = 0; op_in = 0; mem_address_in = 0;
        target_data_in = 0; reg_address_in = 0; mem_ready = 0; mem_rdata = 0;
        env_mem[32'h100] = 8'h78; env_mem[32'h101] = 8'h56;
        env_mem[32'h102] = 8'h34; env_mem[32'h103] = 8'h12;
        env_mem[32'h2003] = 8'h80;
        ref_mem[32'h100] = 8'h78; ref_mem[32'h101] = 8'h56;
        ref_mem[32'h102] = 8'h34; ref_mem[32'h103] = 8'h12;
        ref_mem[32'h2003] = 8'h80;

        // Reset state, with a pass-through request on the inputs
        status_in = 3'b001; reg_address_in = 5'd3; target_data_in = 32'hDEAD;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_stall", 32'(stall_req), 32'd0);
        chk("rst_wb_en", 32'(wb_en), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; status_in = 3'b000;

        // Reset while an LW is at its third byte
        status_in = 3'b011; op_in = `LW; mem_address_in = 32'h300; reg_address_in = 5'd7;
        hit = 0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 32'h302) begin
                hit = 1;
                rst = 1'b1;
                #1;
                chk("midrst_comb_req", 32'(mem_req), 32'd0);
                chk("midrst_comb_stall", 32'(stall_req), 32'd0);
            end else if (mem_req) begin
                mem_ready = 1'b1; mem_rdata = env_rd(mem_addr);
            end
            @(posedge clk); #1;
            mem_ready = 1'b0;
        end
        chk("midrst_reached", 32'(hit), 32'd1);
        rst = 1'b0; status_in = 3'b001; reg_address_in = 5'd5; target_data_in = 32'h12;
        @(negedge clk);
        chk("postrst_mem_req", 32'(mem_req), 32'd0);
        chk("postrst_stall", 32'(stall_req), 32'd0);
        chk("postrst_wb_en", 32'(wb_en), 32'd1);
        chk("postrst_wb_addr", 32'(wb_addr), 32'd5);
        chk("postrst_wb_data", wb_data, 32'h12);
        @(posedge clk); #1;
        status_in = 3'b000;

        // Directed transactions
        run_op(3'b011, `LW,  32'h100, 32'h0, 5'd9, 1);
        run_op(3'b011, `LB,  32'h2003, 32'h0, 5'd10, 0);
        run_op(3'b011, `LBU, 32'h2003, 32'h0, 5'd11, 2);
        run_op(3'b010, `SH,  32'h10, 32'hAABBCCDD, 5'd3, 1);
        run_op(3'b011, `LHU, 32'h10, 32'h0, 5'd4, 0);
        run_op(3'b011, `LW,  32'h100, 32'h0, 5'd12, 3);
        run_op(3'b001, 6'h0, 32'h0, 32'h55, 5'd0, 0);
        run_op(3'b100, 6'h0, 32'h0, 32'h66, 5'd6, 0);
        run_op(3'b101, 6'h0, 32'h0, 32'h404, 5'd1, 0);
        run_op(3'b010, `SW,  32'hFFFFFFFE, 32'h11223344, 5'd0, 0);
        run_op(3'b011, `LH,  32'hFFFFFFFF, 32'h0, 5'd8, 1);
        run_op(3'b011, `LB,  32'h0, 32'h0, 5'd0, 0);

        // Randomized back-to-back traffic
        for (int k = 0; k < 60; k++) begin
            logic [2:0] st;
            logic [5:0] op;
            st = sts[$urandom_range(0, 5)];
            op = 6'($urandom_range(0, 63));
            if (st == 3'b011) op = ld_ops[$urandom_range(0, 4)];
            if (st == 3'b010) op = st_ops[$urandom_range(0, 2)];
            run_op(st, op, 32'($urandom_range(0, 63)), $urandom,
                   5'($urandom_range(0, 31)), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage of the 5-stage RV32I core. Sits between the EX/MEM latch and the MEM/WB latch.
- Consumes the EX result bundle (status, op, address, data, rd).
- Runs loads and stores over the 8-bit memory-controller port, one byte per transfer, little-endian. Stalls the pipeline until the access completes.
- Passes ALU and jump results straight through to writeback.

Parameters:
- ADDR_W, 32, address and data width. Only 32 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- status_in  in  3  000 none, 001 reg write, 010 store, 011 load, 100 branch, 101 jal/jalr
- op_in  in  6  opcode; compared against `LB/`LH/`LW/`LBU/`LHU/`SB/`SH/`SW in Defines.v
- mem_address_in  in  32  effective address
- target_data_in  in  32  store data, or ALU/link result
- reg_address_in  in  5  destination register
- mem_req  out  1  byte transfer request to the memory controller
- mem_we  out  1  1 = write byte, 0 = read byte
- mem_addr  out  32  byte address
- mem_wdata  out  8  write byte
- mem_rdata  in  8  read byte; valid in the cycle mem_ready is high
- mem_ready  in  1  one-cycle pulse: current byte done
- stall_req  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- wb_en  out  1  register write enable to MEM/WB
- wb_addr  out  5  destination register
- wb_data  out  32  writeback value
- fwd_valid  out  1  forward valid to ID
- fwd_addr  out  5  forwarded register
- fwd_data  out  32  forwarded value

Behaviour:
- States: IDLE, ACCESS, DONE. A 2-bit byte counter cnt and a 32-bit load buffer are held internally.
- Access length n: B ops = 1, H ops = 2, W ops = 4.
- While rst=1, every output is driven to 0. On the next clock the state is IDLE, cnt=0 and the buffer is 0.
- A reset during ACCESS abandons the access. Bytes already written stay in memory.

IDLE:
- status_in=001 or 101: wb_en = (reg_address_in != 0), wb_addr = reg_address_in, wb_data = target_data_in. Zero latency, combinational.
- status_in=000 or 100: wb_en=0.
- status_in=010 or 011: latch address, data, op and rd, set cnt=0, go to ACCESS.
- stall_req=1 combinationally in this cycle. wb_en=0.

ACCESS:
- mem_req=1, mem_addr = base+cnt (32-bit wrap), mem_we = (store), mem_wdata = store_data[8*cnt+7 : 8*cnt].
- stall_req=1, wb_en=0.
- On mem_ready, a load captures mem_rdata into buffer byte cnt.
- If cnt = n-1, go to DONE. Otherwise cnt++ and the next address is presented in the following cycle.
- When mem_ready=0, all mem_* outputs hold steady.

DONE (exactly 1 cycle):
- mem_req=0, stall_req=0.
- Load: wb_en = (rd != 0), wb_addr = rd, wb_data = extended buffer.
  - LB: sign-extend bit 7. LBU: zero-extend byte.
  - LH: sign-extend bit 15. LHU: zero-extend halfword.
  - LW: full word.
- Store: wb_en=0.
- Next state is IDLE. Upstream advances at the end of this cycle, so the same instruction is not restarted.

Boundary rules:
- mem_ready in IDLE or DONE is ignored.
- A status_in other than load/store in DONE is not possible, because upstream is frozen.
- A misaligned address is legal; each byte is handled independently.
- Back-to-back memory ops: the second one enters ACCESS from IDLE in the cycle after DONE.
- Load latency is (IDLE cycle) + sum of the per-byte wait cycles + 1 DONE cycle.

Optional Feature:
- Macro MEM_FWD_EN.
- Defined: fwd_valid/fwd_addr/fwd_data mirror wb_en/wb_addr/wb_data in the same cycle, for IDLE pass-through and DONE load results.
- Not defined: fwd_valid, fwd_addr and fwd_data are tied to 0. ID then relies on the MEM/WB register-file path only.

Test Plan:
- Reset mid-LW:
  - Stimulus: rst=1 while ACCESS is at cnt=2.
  - Response: next cycle mem_req=0, stall_req=0, wb_en=0, state IDLE.
  - After reset, an ADD pass-through (status 001, rd=5, data 0x12) gives wb_en=1, wb_data=0x12 with no stall.
- LW at 0x100:
  - Stimulus: memory returns bytes 0x78, 0x56, 0x34, 0x12, with mem_ready one cycle after each request.
  - Response: mem_addr steps 0x100..0x103, stall_req held high throughout, then DONE with wb_data=0x12345678 and rd written.
- LB/LBU at 0x2003 returning 0x80:
  - LB gives wb_data=0xFFFFFF80.
  - LBU gives wb_data=0x00000080.
- SH of data 0xAABBCCDD to 0x10:
  - Response: two writes, (0x10, 0xDD) then (0x11, 0xCC).
  - mem_we=1 on both. wb_en=0 in DONE.
- Stall timing:
  - Stimulus: mem_ready delayed 3 cycles per byte on an LW.
  - Response: mem_* outputs stable while waiting; stall_req high for exactly 17 cycles.
- Edge cases:
  - status 001 with rd=0 gives wb_en=0.
  - Branch status 100 gives wb_en=0.
  - With MEM_FWD_EN defined, fwd_* equal wb_* in the same cycle. Without it, fwd_* stay 0.
